sprite_pipe: RTL and testbench

Parametrised scanline sprite engine for the PPU: evaluates primary OAM for the next scanline, fetches pattern bytes from VRAM, and serialises up to MAX_SPR sprite pixels per line to the PPU pixel mux. Compared with the previous engine it adds:
- a configurable per-line sprite limit of 1–16;
- a 4-cycle fetch per slot;
- transparent-pixel fall-through between slots;
- a sprite-0 tag for hit detection;
- a non-buggy overflow flag.

---
 rtl/sprite_pipe.sv | 216 +++++++++++++++++++++
 tb/tb_sprite_pipe.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_pipe.sv
// rtl/sprite_pipe.sv - scanline sprite evaluation, pattern fetch and pixel serialiser
module sprite_pipe #(
  parameter int MAX_SPR = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [8:0]  cycle_num,
  input  logic [7:0]  scanline_y,
  input  logic        spr_size,
  input  logic        spr_pt_base,
  output logic [7:0]  oam_addr,
  input  logic [7:0]  oam_data,
  output logic        vram_req,
  output logic [13:0] vram_addr,
  input  logic [7:0]  vram_data,
  output logic        overflow,
  output logic        pix_v,
  output logic        pix_prio,
  output logic [3:0]  pix_idx,
  output logic        pix_s0
);
  typedef enum logic [1:0] {IDLE, SCAN, COPY, DONE} state_t;
  localparam logic [4:0] MAX_CNT = 5'(MAX_SPR);

  state_t     state, state_nxt;
  logic [5:0] n;
  logic [1:0] m;
  logic [4:0] cnt;
  logic       s0_in;
  logic [7:0] sy [16];
  logic [7:0] stile [16];
  logic [7:0] sattr [16];
  logic [7:0] sx [16];

  logic [8:0] height;
  logic       in_range;
  assign height   = spr_size ? 9'd16 : 9'd8;
  assign in_range = ({1'b0, oam_data} <= {1'b0, scanline_y}) &&
                    (({1'b0, oam_data} + height) > {1'b0, scanline_y});

  always_comb begin
    state_nxt = state;
    oam_addr  = 8'd0;
    case (state)
      IDLE: if (cycle_num == 9'd64) state_nxt = SCAN;
      SCAN: begin
        oam_addr = {n, 2'b00};
        if (in_range)       state_nxt = (cnt < MAX_CNT) ? COPY : DONE;
        else if (n == 6'd63) state_nxt = DONE;
      end
      COPY: begin
        oam_addr = {n, m};
        if (m == 2'd3) state_nxt = (n == 6'd63) ? DONE : SCAN;
      end
      DONE: if (cycle_num == 9'd257) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      n        <= 6'd0;
      m        <= 2'd0;
      cnt      <= 5'd0;
      s0_in    <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (cycle_num == 9'd64) begin
          n        <= 6'd0;
          cnt      <= 5'd0;
          s0_in    <= 1'b0;
          overflow <= 1'b0;
        end
        SCAN: begin
          if (in_range) begin
            if (cnt < MAX_CNT) begin
              m <= 2'd1;
              if (n == 6'd0) s0_in <= 1'b1;
            end else begin
              overflow <= 1'b1;
            end
          end else begin
            n <= n + 6'd1;
          end
        end
        COPY: begin
          if (m == 2'd3) begin
            cnt <= cnt + 5'd1;
            n   <= n + 6'd1;
          end else begin
            m <= m + 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Secondary OAM needs no reset: entries beyond cnt are never fetched.
  always_ff @(posedge clock) begin
    if (state == SCAN && in_range && cnt < MAX_CNT) sy[cnt[3:0]] <= oam_data;
    if (state == COPY) begin
      case (m)
        2'd1:    stile[cnt[3:0]] <= oam_data;
        2'd2:    sattr[cnt[3:0]] <= oam_data;
        2'd3:    sx[cnt[3:0]]    <= oam_data;
        default: ;
      endcase
    end
  end

  logic       fetch_win, render_win, slot_en;
  logic [5:0] fo;
  logic [3:0] k, row_raw, row;
  logic [1:0] p;
  logic [7:0] fa, ft, cap_byte, f_lo;
  logic [13:0] fetch_addr;

  assign fetch_win  = (cycle_num >= 9'd257) && (cycle_num <= 9'd320);
  assign render_win = (cycle_num >= 9'd1) && (cycle_num <= 9'd256);
  assign fo         = 6'(cycle_num - 9'd257);
  assign k          = fo[5:2];
  assign p          = fo[1:0];
  assign slot_en    = fetch_win && ({1'b0, k} < cnt) && ({1'b0, k} < MAX_CNT);
  assign fa         = sattr[k];
  assign ft         = stile[k];
  assign row_raw    = 4'(scanline_y - sy[k]);
  assign row        = fa[7] ? (row_raw ^ (spr_size ? 4'hF : 4'h7)) : row_raw;
  assign fetch_addr = spr_size ? {1'b0, ft[0], ft[7:1], row[3], p[1], row[2:0]}
                               : {1'b0, spr_pt_base, ft, p[1], row[2:0]};
  assign vram_req   = slot_en && !p[0];
  assign vram_addr  = vram_req ? fetch_addr : 14'd0;
  assign cap_byte   = fa[6] ? {vram_data[0], vram_data[1], vram_data[2], vram_data[3],
                               vram_data[4], vram_data[5], vram_data[6], vram_data[7]}
                            : vram_data;

  logic       slot_valid [MAX_SPR];
  logic [7:0] slot_lo    [MAX_SPR];
  logic [7:0] slot_hi    [MAX_SPR];
  logic [7:0] slot_x     [MAX_SPR];
  logic [1:0] slot_pal   [MAX_SPR];
  logic       slot_prio  [MAX_SPR];
  logic       s0_tag;

  always_ff @(posedge clock) begin
    if (reset) begin
      f_lo   <= 8'd0;
      s0_tag <= 1'b0;
    end else begin
      if (slot_en && p == 2'd1) f_lo <= cap_byte;
      if (fetch_win && p == 2'd3 && k == 4'd0) s0_tag <= slot_en && s0_in;
    end
  end

  always_ff @(posedge clock) begin
    for (int i = 0; i < MAX_SPR; i++) begin
      if (reset) begin
        slot_valid[i] <= 1'b0;
        slot_lo[i]    <= 8'd0;
        slot_hi[i]    <= 8'd0;
        slot_x[i]     <= 8'd0;
        slot_pal[i]   <= 2'd0;
        slot_prio[i]  <= 1'b0;
      end else if (fetch_win && p == 2'd3 && k == 4'(i)) begin
        slot_valid[i] <= slot_en;
        slot_lo[i]    <= slot_en ? f_lo : 8'd0;
        slot_hi[i]    <= slot_en ? cap_byte : 8'd0;
        slot_x[i]     <= slot_en ? sx[k] : 8'd0;
        slot_pal[i]   <= slot_en ? fa[1:0] : 2'd0;
        slot_prio[i]  <= slot_en && fa[5];
      end else if (render_win) begin
        if (slot_x[i] != 8'd0) begin
          slot_x[i] <= slot_x[i] - 8'd1;
        end else begin
          slot_lo[i] <= {slot_lo[i][6:0], 1'b0};
          slot_hi[i] <= {slot_hi[i][6:0], 1'b0};
        end
      end
    end
  end

  // Walk from the highest slot down so the lowest-index opaque slot wins.
  logic       win_v, win_prio, win_s0;
  logic [3:0] win_idx;
  always_comb begin
    win_v    = 1'b0;
    win_prio = 1'b0;
    win_idx  = 4'd0;
    win_s0   = 1'b0;
    for (int i = MAX_SPR - 1; i >= 0; i--) begin
      if (slot_valid[i] && slot_x[i] == 8'd0 && (slot_hi[i][7] || slot_lo[i][7])) begin
        win_v    = 1'b1;
        win_prio = slot_prio[i];
        win_idx  = {slot_pal[i], slot_hi[i][7], slot_lo[i][7]};
        win_s0   = (i == 0) && s0_tag;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset || !render_win) begin
      pix_v    <= 1'b0;
      pix_prio <= 1'b0;
      pix_idx  <= 4'd0;
      pix_s0   <= 1'b0;
    end else begin
      pix_v    <= win_v;
      pix_prio <= win_prio;
      pix_idx  <= win_idx;
      pix_s0   <= win_s0;
    end
  end
endmodule

// File: tb/tb_sprite_pipe.sv
// tb/tb_sprite_pipe.sv - directed scoreboard bench for sprite_pipe
module tb_sprite_pipe;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [8:0]  cycle_num = 9'd0;
  logic [7:0]  scanline_y = 8'd0;
  logic        spr_size = 1'b0;
  logic        spr_pt_base = 1'b0;
  logic [7:0]  oam_addr, oam_data, oam_addr16, oam_data16;
  logic        vram_req, vram_req16;
  logic [13:0] vram_addr, vram_addr16;
  logic [7:0]  vram_data, vram_data16;
  logic        overflow, overflow16;
  logic        pix_v, pix_prio, pix_s0, v16, prio16, s016;
  logic [3:0]  pix_idx, idx16;

  logic [7:0] oam_mem [256];
  logic [7:0] vram_mem [16384];

  typedef struct {
    string       tag;
    int          cyc;
    int          kind;
    logic [15:0] exp;
  } exp_t;
  exp_t exp_q[$];

  int n_assert = 0;
  int n_fail = 0;
  int req8, req16, req16_late;

  always #5 clock = ~clock;

  assign oam_data   = oam_mem[oam_addr];
  assign oam_data16 = oam_mem[oam_addr16];
  always @(posedge clock) begin
    vram_data   <= vram_mem[vram_addr];
    vram_data16 <= vram_mem[vram_addr16];
  end

  sprite_pipe #(.MAX_SPR(8)) dut (
    .clock(clock), .reset(reset), .cycle_num(cycle_num), .scanline_y(scanline_y),
    .spr_size(spr_size), .spr_pt_base(spr_pt_base), .oam_addr(oam_addr), .oam_data(oam_data),
    .vram_req(vram_req), .vram_addr(vram_addr), .vram_data(vram_data), .overflow(overflow),
    .pix_v(pix_v), .pix_prio(pix_prio), .pix_idx(pix_idx), .pix_s0(pix_s0)
  );

  sprite_pipe #(.MAX_SPR(16)) dut16 (
    .clock(clock), .reset(reset), .cycle_num(cycle_num), .scanline_y(scanline_y),
    .spr_size(spr_size), .spr_pt_base(spr_pt_base), .oam_addr(oam_addr16), .oam_data(oam_data16),
    .vram_req(vram_req16), .vram_addr(vram_addr16), .vram_data(vram_data16), .overflow(overflow16),
    .pix_v(v16), .pix_prio(prio16), .pix_idx(idx16), .pix_s0(s016)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // kind: 0 pixel bundle, 1 vram {req,addr}, 2 overflow, 3 overflow (16-slot), 4 oam_addr
  function automatic logic [15:0] observe(input int kind);
    case (kind)
      0:       return {9'd0, pix_v, pix_prio, pix_idx, pix_s0};
      1:       return {1'b0, vram_req, vram_addr};
      2:       return {15'd0, overflow};
      3:       return {15'd0, overflow16};
      default: return {8'd0, oam_addr};
    endcase
  endfunction

  function automatic logic [15:0] pix(input logic v, input logic prio, input logic [3:0] idx,
                                      input logic s0);
    return {9'd0, v, prio, idx, s0};
  endfunction

  function automatic logic [15:0] vr(input logic req, input logic [13:0] a);
    return {1'b0, req, a};
  endfunction

  task automatic push(input string tag, input int cyc, input int kind, input logic [15:0] e);
    exp_t x;
    x.tag  = tag;
    x.cyc  = cyc;
    x.kind = kind;
    x.exp  = e;
    exp_q.push_back(x);
  endtask

  task automatic clear_oam();
    for (int i = 0; i < 256; i++) oam_mem[i] = 8'hFF;
  endtask

  task automatic set_spr(input int idx, input logic [7:0] y, input logic [7:0] tile,
                         input logic [7:0] attr, input logic [7:0] x);
    oam_mem[idx*4]   = y;
    oam_mem[idx*4+1] = tile;
    oam_mem[idx*4+2] = attr;
    oam_mem[idx*4+3] = x;
  endtask

  // One full line: inputs change 1 time unit after the edge, outputs sampled on the falling edge.
  task automatic run_line(input logic [7:0] y, input int rst_cyc);
    exp_t e;
    req8 = 0;
    req16 = 0;
    req16_late = 0;
    for (int c = 0; c <= 340; c++) begin
      @(posedge clock);
      #1;
      cycle_num  = 9'(c);
      scanline_y = y;
      reset      = (c == rst_cyc);
      @(negedge clock);
      if (vram_req) req8++;
      if (vram_req16) begin
        req16++;
        if (c >= 290 && c <= 320) req16_late++;
      end
      while (exp_q.size() > 0 && exp_q[0].cyc == c) begin
        e = exp_q.pop_front();
        check(e.tag, observe(e.kind), e.exp);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 16384; i++) vram_mem[i] = 8'h00;
    clear_oam();

    repeat (2) @(posedge clock);
    @(negedge clock);
    check("reset_pix", observe(0), 16'd0);
    check("reset_vram", observe(1), 16'd0);
    check("reset_ovf", observe(2), 16'd0);
    check("reset_oam", observe(4), 16'd0);

    // One 8x8 sprite in OAM entry 1, evaluated on line 12
    set_spr(1, 8'd10, 8'h42, 8'h01, 8'd5);
    vram_mem[14'h1422] = 8'h80;
    vram_mem[14'h142A] = 8'h00;
    spr_size = 1'b0;
    spr_pt_base = 1'b1;
    push("ovf_one", 200, 2, 16'd0);
    push("fetch_lo_one", 257, 1, vr(1'b1, 14'h1422));
    push("fetch_gap_one", 258, 1, vr(1'b0, 14'h0));
    push("fetch_hi_one", 259, 1, vr(1'b1, 14'h142A));
    push("fetch_slot1_off", 261, 1, vr(1'b0, 14'h0));
    run_line(8'd12, -1);
    check("req_count_one", 16'(req8), 16'd2);

    // Flipped 8x16 sprite; this line renders the first sprite
    clear_oam();
    set_spr(1, 8'd0, 8'h43, 8'hC0, 8'd0);
    vram_mem[14'h1434] = 8'h01;
    vram_mem[14'h143C] = 8'h00;
    spr_size = 1'b1;
    push("pix_c1_idle", 1, 0, pix(1'b0, 1'b0, 4'h0, 1'b0));
    push("pix_before_x", 6, 0, pix(1'b0, 1'b0, 4'h0, 1'b0));
    push("pix_one", 7, 0, pix(1'b1, 1'b0, 4'h5, 1'b0));
    push("pix_after_one", 8, 0, pix(1'b0, 1'b0, 4'h0, 1'b0));
    push("fetch_lo_flip", 257, 1, vr(1'b1, 14'h1434));
    push("pix_c258_idle", 258, 0, pix(1'b0, 1'b0, 4'h0, 1'b0));
    push("fetch_hi_flip", 259, 1, vr(1'b1, 14'h143C));
    run_line(8'd3, -1);

    // Slot 0 (OAM 0) transparent at its first pixel, slot 1 opaque behind it
    clear_oam();
    set_spr(0, 8'd50, 8'h10, 8'h00, 8'd20);
    set_spr(1, 8'd50, 8'h11, 8'h02, 8'd20);
    vram_mem[14'h100] = 8'h7F;
    vram_mem[14'h108] = 8'h00;
    vram_mem[14'h110] = 8'hFF;
    vram_mem[14'h118] = 8'hFF;
    spr_size = 1'b0;
    spr_pt_base = 1'b0;
    push("pix_flip_left", 2, 0, pix(1'b1, 1'b0, 4'h1, 1'b0));
    push("pix_flip_next", 3, 0, pix(1'b0, 1'b0, 4'h0, 1'b0));
    run_line(8'd50, -1);

    // Nine sprites in range: overflow on the 8-slot engine only
    clear_oam();
    for (int i = 0; i < 9; i++) set_spr(i, 8'd20, 8'(8'h50 + i), 8'h00, 8'd200);
    push("pix_prio_pre", 21, 0, pix(1'b0, 1'b0, 4'h0, 1'b0));
    push("pix_fallthru", 22, 0, pix(1'b1, 1'b0, 4'hB, 1'b0));
    push("pix_s0", 23, 0, pix(1'b1, 1'b0, 4'h1, 1'b1));
    push("oam_copy_tile", 66, 4, 16'd1);
    push("oam_scan_n1", 69, 4, 16'd4);
    push("ovf_before", 97, 2, 16'd0);
    push("ovf_set", 98, 2, 16'd1);
    push("ovf_hold", 200, 2, 16'd1);
    push("ovf16_clear", 200, 3, 16'd0);
    run_line(8'd22, -1);
    check("req_count_max8", 16'(req8), 16'd16);
    check("req_count_max16", 16'(req16), 16'd18);

    // Y=0xF8 with 8x16 on line 7 must not wrap into range
    clear_oam();
    set_spr(0, 8'hF8, 8'h01, 8'h00, 8'd0);
    spr_size = 1'b1;
    push("ovf_hold_next", 63, 2, 16'd1);
    push("ovf_cleared", 65, 2, 16'd0);
    run_line(8'd7, -1);
    check("req_no_wrap", 16'(req8), 16'd0);
    check("req16_no_wrap", 16'(req16), 16'd0);

    // Y = line-7 in range, Y = line-8 out of range
    clear_oam();
    set_spr(0, 8'd93, 8'h20, 8'h00, 8'd0);
    set_spr(1, 8'd92, 8'h21, 8'h00, 8'd0);
    spr_size = 1'b0;
    push("fetch_row7", 257, 1, vr(1'b1, 14'h207));
    push("fetch_ybelow_off", 261, 1, vr(1'b0, 14'h0));
    run_line(8'd100, -1);
    check("req_y_edge", 16'(req8), 16'd2);

    // Twelve opaque sprites at X=0, reset mid-fetch at cycle 290
    clear_oam();
    for (int i = 0; i < 12; i++) set_spr(i, 8'd150, 8'h60, 8'h00, 8'd0);
    vram_mem[14'h600] = 8'hFF;
    push("ovf_pre_reset", 200, 2, 16'd1);
    push("fetch_slot8_max8", 289, 1, vr(1'b0, 14'h0));
    push("rst_ovf", 291, 2, 16'd0);
    push("rst_vram", 291, 1, vr(1'b0, 14'h0));
    push("rst_pix", 291, 0, pix(1'b0, 1'b0, 4'h0, 1'b0));
    push("rst_oam", 291, 4, 16'd0);
    run_line(8'd150, 290);
    check("req16_pre_reset", 16'(req16), 16'd17);
    check("req16_after_reset", 16'(req16_late), 16'd0);

    clear_oam();
    push("pix_gone_after_reset", 2, 0, pix(1'b0, 1'b0, 4'h0, 1'b0));
    push("ovf_after_reset", 30, 2, 16'd0);
    run_line(8'd151, -1);

    check("scoreboard_drained", 16'(exp_q.size()), 16'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
